// File: rtl/servo_pwm_ctrl_if.sv
// Port-mapped command channel from the 8051: channel/strobe on P1_o,
// position on P2_o, ack returned on a spare P1_i bit.
interface servo_pwm_ctrl_if;
  logic [7:0] cmd_i;
  logic [7:0] pos_i;
  logic       cmd_ack;

  modport master (output cmd_i, output pos_i, input cmd_ack);
  modport slave  (input cmd_i, input pos_i, output cmd_ack);
endinterface

// File: rtl/servo_pwm_ctrl.sv
// Servo scheduler: 4-phase command capture into shadow registers, commit at
// each frame wrap, and NUM_CH registered PWM outputs timed in 1 us ticks.

module servo_pwm_lane #(
  parameter int US_W    = 15,
  parameter int MIN_US  = 1000,
  parameter int STEP_US = 4
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_pos,
  input  logic            commit,
  input  logic [US_W-1:0] us_nxt,
  output logic            pwm
);
  logic [7:0]  shadow, active, act_nxt;
  logic [31:0] width;

  // Commit samples shadow before this cycle's write lands (old value wins).
  assign act_nxt = commit ? shadow : active;
  assign width   = 32'(MIN_US) + 32'(act_nxt) * 32'(STEP_US);

  // pwm is computed from next-state values so it lines up with us_cnt.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shadow <= 8'hFF;
      active <= 8'hFF;
      pwm    <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_pos;
      active <= act_nxt;
      pwm    <= (act_nxt != 8'hFF) && (32'(us_nxt) < width);
    end
  end
endmodule

module servo_pwm_ctrl #(
  parameter int NUM_CH    = 16,
  parameter int TICK_DIV  = 24,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int STEP_US   = 4,
  parameter int POS_MAX   = 250
) (
  input  logic                clk,
  input  logic                n_reset,
  servo_pwm_ctrl_if.slave     bus,
  output logic                frame_o,
  output logic [NUM_CH-1:0]   pwm_o
);
  localparam int PR_W = $clog2(TICK_DIV);
  localparam int US_W = $clog2(PERIOD_US);

  typedef enum logic [1:0] {IDLE, LATCH, ACK} hs_state_e;
  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] pos;
  } servo_req_t;

  hs_state_e       state, state_nxt;
  servo_req_t      req_q;
  logic            cmd_ack_q;
  logic [7:0]      wr_pos;
  logic            wr_ok;
  logic            cmd_unused;

  logic [PR_W-1:0] presc;
  logic [US_W-1:0] us_cnt, us_nxt;
  logic            tick, wrap;

  assign cmd_unused = ^bus.cmd_i[6:4];
  assign bus.cmd_ack = cmd_ack_q;

  // ---- timebase ----
  assign tick = (presc == PR_W'(TICK_DIV - 1));
  assign wrap = tick && (us_cnt == US_W'(PERIOD_US - 1));

  always_comb begin
    us_nxt = us_cnt;
    if (wrap)      us_nxt = '0;
    else if (tick) us_nxt = us_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      presc   <= '0;
      us_cnt  <= '0;
      frame_o <= 1'b0;
    end else begin
      presc   <= tick ? '0 : presc + 1'b1;
      us_cnt  <= us_nxt;
      frame_o <= wrap;
    end
  end

  // ---- handshake FSM ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_i[7]) state_nxt = LATCH;
      LATCH:   state_nxt = ACK;
      ACK:     if (!bus.cmd_i[7]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      cmd_ack_q <= 1'b0;
      req_q     <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ack_q <= (state_nxt == ACK);
      if (state == IDLE && bus.cmd_i[7]) req_q <= '{ch: bus.cmd_i[3:0], pos: bus.pos_i};
    end
  end

  // 0xFF is the "off" code and must pass through the clamp untouched.
  assign wr_pos = (req_q.pos == 8'hFF)          ? 8'hFF :
                  (req_q.pos > 8'(POS_MAX))     ? 8'(POS_MAX) : req_q.pos;
  assign wr_ok  = (state == LATCH) && (32'(req_q.ch) < NUM_CH);

  // ---- per-channel lanes ----
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_lane #(
      .US_W   (US_W),
      .MIN_US (MIN_US),
      .STEP_US(STEP_US)
    ) u_lane (
      .clk    (clk),
      .n_reset(n_reset),
      .wr_en  (wr_ok && (req_q.ch == 4'(g))),
      .wr_pos (wr_pos),
      .commit (wrap),
      .us_nxt (us_nxt),
      .pwm    (pwm_o[g])
    );
  end
endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Bench for servo_pwm_ctrl: table of writes, per-frame expected widths queued
// and checked by a pulse-width monitor, plus timed wrap and reset sequences.
`timescale 1ns/1ps
module tb_servo_pwm_ctrl;
  localparam int NCH       = 8;
  localparam int TDIV      = 2;
  localparam int PER       = 3000;
  localparam int FRAME_CLK = TDIV * PER;
  localparam int NV        = 11;

  logic           clk = 1'b0;
  logic           n_reset = 1'b0;
  logic           frame_o;
  logic [NCH-1:0] pwm_o;

  servo_pwm_ctrl_if bus();

  servo_pwm_ctrl #(
    .NUM_CH(NCH), .TICK_DIV(TDIV), .PERIOD_US(PER),
    .MIN_US(1000), .STEP_US(4), .POS_MAX(250)
  ) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus), .frame_o(frame_o), .pwm_o(pwm_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ch;
    logic [7:0] pos;
    int         exp_us;   // -1: no channel may change
    bit         last;     // last write of this frame
    int         hold;
  } vec_t;
  typedef struct { int w[NCH]; } frame_exp_t;

  int         errs = 0, checks = 0, cyc = 0, fcyc = 0;
  int         exp_w[NCH];
  frame_exp_t sb[$];
  frame_exp_t mon_e;
  int         hi_cnt[NCH];
  int         since = 0, fno = 0;
  bit         have_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic void push_exp();
    frame_exp_t e;
    for (int i = 0; i < NCH; i++) e.w[i] = exp_w[i];
    sb.push_back(e);
  endfunction

  // Frame monitor: period between frame_o pulses and high time per channel.
  always @(negedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
      since = 0;
      have_prev = 0;
    end else begin
      since++;
      if (frame_o) begin
        if (have_prev) begin
          chk("frame_period", since, FRAME_CLK);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            for (int i = 0; i < NCH; i++)
              chk($sformatf("pwm_width f%0d ch%0d", fno, i), hi_cnt[i], mon_e.w[i] * TDIV);
          end
        end
        have_prev = 1;
        since = 0;
        fno++;
        for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
      end
      for (int i = 0; i < NCH; i++) if (pwm_o[i]) hi_cnt[i]++;
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_o && n < FRAME_CLK + 1000);
    if (!frame_o) chk("frame_timeout", n, FRAME_CLK);
    fcyc = cyc;
  endtask

  // Full 4-phase write; inputs are scrambled after capture to prove they are ignored.
  task automatic write_cmd(input logic [3:0] ch, input logic [7:0] pos,
                           input int hold, input int at_cyc);
    int n = 0;
    while (cyc < at_cyc) @(negedge clk);
    bus.cmd_i = {1'b1, 3'b000, ch};
    bus.pos_i = pos;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin
        bus.pos_i      = ~pos;
        bus.cmd_i[3:0] = ch ^ 4'h1;
      end
    end while (!bus.cmd_ack && n < 10);
    chk("ack_latency", n, 2);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk("ack_held", int'(bus.cmd_ack), 1);
    bus.cmd_i = 8'h00;
    bus.pos_i = 8'h5A;
    @(negedge clk);
    chk("ack_release", int'(bus.cmd_ack), 0);
  endtask

  initial begin
    vec_t tab[NV];
    int   n, rel;

    tab[0]  = '{4'd3,  8'd0,   1000, 1'b0, 0};
    tab[1]  = '{4'd3,  8'd250, 2000, 1'b1, 0};
    tab[2]  = '{4'd0,  8'd125, 1500, 1'b0, 0};
    tab[3]  = '{4'd5,  8'd1,   1004, 1'b1, 0};
    tab[4]  = '{4'd0,  8'hC8,  1800, 1'b1, 0};
    tab[5]  = '{4'd0,  8'hFF,  0,    1'b0, 0};
    tab[6]  = '{4'd15, 8'd10,  -1,   1'b1, 50};
    tab[7]  = '{4'd0,  8'hFE,  2000, 1'b0, 0};
    tab[8]  = '{4'd3,  8'hFF,  0,    1'b0, 0};
    tab[9]  = '{4'd7,  8'd251, 2000, 1'b0, 0};
    tab[10] = '{4'd1,  8'd0,   1000, 1'b1, 0};

    bus.cmd_i = 8'h00;
    bus.pos_i = 8'h00;
    for (int i = 0; i < NCH; i++) exp_w[i] = 0;

    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(pwm_o), 0);
    chk("rst_ack", int'(bus.cmd_ack), 0);
    chk("rst_frame", int'(frame_o), 0);
    n_reset = 1'b1;

    wait_frame();
    push_exp();
    for (int i = 0; i < NV; i++) begin
      write_cmd(tab[i].ch, tab[i].pos, tab[i].hold, 0);
      if (tab[i].exp_us >= 0) exp_w[tab[i].ch] = tab[i].exp_us;
      if (tab[i].last && i < NV - 1) begin
        wait_frame();
        push_exp();
      end
    end

    // Write whose LATCH cycle is the wrap-tick cycle: old width next frame.
    push_exp();
    write_cmd(4'd1, 8'd50, 0, fcyc + FRAME_CLK - 2);
    exp_w[1] = 1200;
    wait_frame();
    push_exp();
    wait_frame();

    write_cmd(4'd2, 8'd250, 0, 0);
    wait_frame();
    repeat (10) @(negedge clk);
    chk("pwm_mid_frame", int'(pwm_o), 8'hA7);

    // Reset while acking and while pulses are high.
    bus.cmd_i = 8'h84;
    bus.pos_i = 8'd0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ack && n < 10);
    chk("ack_before_reset", int'(bus.cmd_ack), 1);
    n_reset = 1'b0;
    #1;
    chk("rst_async_pwm", int'(pwm_o), 0);
    chk("rst_async_ack", int'(bus.cmd_ack), 0);
    bus.cmd_i = 8'h00;
    sb.delete();
    for (int i = 0; i < NCH; i++) exp_w[i] = 0;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    rel = cyc;

    write_cmd(4'd4, 8'd50, 0, 0);
    exp_w[4] = 1200;
    wait_frame();
    chk("first_frame_after_reset", fcyc - rel, FRAME_CLK);
    push_exp();
    wait_frame();
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
